// File: rtl/uart_rx_ctrl_pkg.sv
// Shared types and defaults for the UART receive controller.
// Includes the state encoding and the counter-width helper.
package uart_rx_ctrl_pkg;

    localparam int unsigned DEFAULT_DATA_WIDTH = 8;
    localparam int unsigned DEFAULT_OVERSAMPLE = 16;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP,
        RX_WAIT_HIGH
    } rx_state_e;

    // Counter width for values 0..n-1, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/uart_rx_ctrl_if.sv
// Serial line and deserialiser-facing pulses of the UART receiver.
// The master side is the controller; the slave side drives rx and consumes the pulses.
interface uart_rx_ctrl_if;
    logic rx;
    logic shift;
    logic serial_in;
    logic rx_done;
    logic frame_err;
    logic busy;

    modport master (
        input  rx,
        output shift,
        output serial_in,
        output rx_done,
        output frame_err,
        output busy
    );

    modport slave (
        output rx,
        input  shift,
        input  serial_in,
        input  rx_done,
        input  frame_err,
        input  busy
    );
endinterface

// File: rtl/uart_rx_ctrl_sync_2ff.sv
// Two-flop synchroniser for asynchronous inputs.
// Both flops reset synchronously to RESET_VAL.
module sync_2ff #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [1:0] ff;

    always_ff @(posedge clk) begin
        if (rst) begin
            ff <= {2{RESET_VAL}};
        end else begin
            ff <= {ff[0], d};
        end
    end

    assign q = ff[1];

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive bit-timing controller: start-bit validation, mid-bit data
// sampling with shift/serial_in strobes, and stop-bit checking.
module uart_rx_ctrl
    import uart_rx_ctrl_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int unsigned OVERSAMPLE = DEFAULT_OVERSAMPLE
) (
    input  logic          rx_clk,
    input  logic          rst,
    uart_rx_ctrl_if.master bus
);

    localparam int unsigned CNT_W = cnt_width(OVERSAMPLE);
    localparam int unsigned IDX_W = cnt_width(DATA_WIDTH);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(OVERSAMPLE / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OVERSAMPLE - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_WIDTH - 1);

    logic rx_s;

    sync_2ff #(.RESET_VAL(1'b1)) u_sync (
        .clk (rx_clk),
        .rst (rst),
        .d   (bus.rx),
        .q   (rx_s)
    );

    rx_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0] bit_idx_q, bit_idx_d;
    logic             shift_q, shift_d;
    logic             serial_in_q, serial_in_d;
    logic             rx_done_q, rx_done_d;
    logic             frame_err_q, frame_err_d;
    logic             busy_q, busy_d;

    always_ff @(posedge rx_clk) begin
        if (rst) begin
            state_q     <= RX_IDLE;
            cnt_q       <= '0;
            bit_idx_q   <= '0;
            shift_q     <= 1'b0;
            serial_in_q <= 1'b1;
            rx_done_q   <= 1'b0;
            frame_err_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            serial_in_q <= serial_in_d;
            rx_done_q   <= rx_done_d;
            frame_err_q <= frame_err_d;
            busy_q      <= busy_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bit_idx_d   = bit_idx_q;
        shift_d     = 1'b0;
        serial_in_d = serial_in_q;
        rx_done_d   = 1'b0;
        frame_err_d = 1'b0;

        case (state_q)
            RX_IDLE: begin
                if (!rx_s) begin
                    state_d = RX_START;
                    cnt_d   = '0;
                end
            end
            RX_START: begin
                if (cnt_q == CNT_HALF) begin
                    if (!rx_s) begin
                        state_d   = RX_DATA;
                        cnt_d     = '0;
                        bit_idx_d = '0;
                    end else begin
                        state_d = RX_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RX_DATA: begin
                if (cnt_q == CNT_LAST) begin
                    serial_in_d = rx_s;
                    shift_d     = 1'b1;
                    cnt_d       = '0;
                    if (bit_idx_q == IDX_LAST) begin
                        state_d = RX_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RX_STOP: begin
                // Leaving at mid-stop-bit leaves half a bit to catch a back-to-back start edge.
                if (cnt_q == CNT_LAST) begin
                    cnt_d = '0;
                    if (rx_s) begin
                        rx_done_d = 1'b1;
                        state_d   = RX_IDLE;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = RX_WAIT_HIGH;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RX_WAIT_HIGH: begin
                if (rx_s) begin
                    state_d = RX_IDLE;
                end
            end
            default: begin
                state_d = RX_IDLE;
            end
        endcase

        busy_d = (state_d != RX_IDLE);
    end

    assign bus.shift     = shift_q;
    assign bus.serial_in = serial_in_q;
    assign bus.rx_done   = rx_done_q;
    assign bus.frame_err = frame_err_q;
    assign bus.busy      = busy_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for uart_rx_ctrl with a cycle-stamped scoreboard of
// expected shift/rx_done/frame_err pulses (OVERSAMPLE=16, DATA_WIDTH=8).
module tb_uart_rx_ctrl;

    localparam int OS = 16;
    localparam int DW = 8;
    localparam int K_SHIFT = 0;
    localparam int K_DONE  = 1;
    localparam int K_FERR  = 2;

    typedef struct {
        int cyc;
        int kind;
        int val;
    } evt_t;

    logic clk;
    logic rst;
    uart_rx_ctrl_if bus ();

    uart_rx_ctrl #(.DATA_WIDTH(DW), .OVERSAMPLE(OS)) dut (
        .rx_clk (clk),
        .rst    (rst),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   tests;
    int   fails;
    int   cyc;
    int   busy_cnt;
    evt_t sb[$];

    task automatic chk(input string tag, input int obs, input int exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // One clock: outputs are examined 1ns after the rising edge.
    task automatic step();
        int   n;
        int   kind;
        evt_t e;
        @(posedge clk);
        #1;
        cyc++;
        if (bus.busy === 1'b1) busy_cnt++;
        while (sb.size() > 0 && sb[0].cyc < cyc) begin
            e = sb.pop_front();
            chk("missed_event_cycle", cyc, e.cyc);
        end
        if (bus.shift === 1'b1 || bus.rx_done === 1'b1 || bus.frame_err === 1'b1) begin
            n = int'(bus.shift) + int'(bus.rx_done) + int'(bus.frame_err);
            chk("pulse_exclusive", n, 1);
            kind = bus.shift ? K_SHIFT : (bus.rx_done ? K_DONE : K_FERR);
            if (sb.size() == 0) begin
                chk("unexpected_pulse_kind", kind, -1);
            end else begin
                e = sb.pop_front();
                chk("event_kind", kind, e.kind);
                chk("event_cycle", cyc, e.cyc);
                if (kind == K_SHIFT) chk("serial_in", int'(bus.serial_in), e.val);
            end
        end
    endtask

    task automatic hold(input logic v, input int n);
        bus.rx = v;
        repeat (n) step();
    endtask

    // Line goes low right after edge c, so idle sees rx_s low at edge c+3 (D).
    task automatic push_bits(input logic [7:0] data, input int nbits, input int c);
        for (int k = 0; k < nbits; k++)
            sb.push_back('{cyc: c + 3 + OS/2 + (k + 1) * OS, kind: K_SHIFT, val: int'(data[k])});
    endtask

    task automatic send_frame(input logic [7:0] data, input logic stop);
        int c;
        c = cyc;
        push_bits(data, DW, c);
        sb.push_back('{cyc: c + 3 + OS/2 + (DW + 1) * OS, kind: (stop ? K_DONE : K_FERR), val: 0});
        hold(1'b0, OS);
        for (int k = 0; k < DW; k++) hold(data[k], OS);
        hold(stop, OS);
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_shift"},     int'(bus.shift), 0);
        chk({tag, "_serial_in"}, int'(bus.serial_in), 1);
        chk({tag, "_rx_done"},   int'(bus.rx_done), 0);
        chk({tag, "_frame_err"}, int'(bus.frame_err), 0);
        chk({tag, "_busy"},      int'(bus.busy), 0);
    endtask

    initial begin
        int c;
        tests    = 0;
        fails    = 0;
        cyc      = 0;
        busy_cnt = 0;
        rst      = 1'b1;
        bus.rx   = 1'b1;
        repeat (3) step();
        check_reset_vals("reset");
        rst = 1'b0;
        hold(1'b1, 10);

        // Good frame 0xA5
        send_frame(8'hA5, 1'b1);
        hold(1'b1, 10);
        chk("sb_empty_a5", sb.size(), 0);

        // Four-cycle glitch: false start, no pulses
        busy_cnt = 0;
        hold(1'b0, 4);
        hold(1'b1, 30);
        chk("glitch_busy_seen", int'(busy_cnt > 0), 1);
        chk("glitch_busy_le9", int'(busy_cnt <= 9), 1);
        chk("glitch_idle", int'(bus.busy), 0);

        // Framing error, stuck-low line, then a good frame
        send_frame(8'h3C, 1'b0);
        hold(1'b0, 40);
        chk("wait_high_busy", int'(bus.busy), 1);
        hold(1'b1, 20);
        chk("wait_high_released", int'(bus.busy), 0);
        chk("sb_empty_3c", sb.size(), 0);
        send_frame(8'h81, 1'b1);
        hold(1'b1, 10);
        chk("sb_empty_81", sb.size(), 0);

        // Back-to-back frames; rx_done stamps are 160 cycles apart
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        hold(1'b1, 10);
        chk("sb_empty_b2b", sb.size(), 0);

        // Reset one cycle after the 4th shift of a 0xC3 frame
        c = cyc;
        push_bits(8'hC3, 4, c);
        hold(1'b0, OS);
        hold(1'b1, OS);
        hold(1'b1, OS);
        hold(1'b0, OS);
        hold(1'b0, 11);
        chk("fourth_shift_seen", sb.size(), 0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_reset_vals("midframe_reset");
        hold(1'b1, 200);
        chk("sb_empty_after_reset", sb.size(), 0);
        send_frame(8'h5A, 1'b1);
        hold(1'b1, 10);
        chk("sb_empty_5a", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/uart_rx_ctrl.md
# uart_rx_ctrl

Receive-side bit-timing controller for the UART receiver. It synchronises the asynchronous serial line to the oversampled `rx_clk` and detects and validates the start bit. It then samples each data bit at mid-bit and drives the `shift`/`serial_in` pair consumed by the downstream `sipo` deserialiser. At the end of each frame it checks the stop bit and reports `rx_done` or `frame_err`.

## Interface
- `DATA_WIDTH`, default `` `DATA_WIDTH `` (from `uart_params.vh`): data bits per frame.
- `OVERSAMPLE`, default 16: `rx_clk` cycles per bit period. Even, ≥4.
- `rx_clk`  in  1  oversampled receive clock; sole clock.
- `rst`  in  1  synchronous, active-high reset.
- `rx`  in  1  asynchronous serial line; idles high.
- `shift`  out  1  one-cycle pulse; `serial_in` holds a valid data bit.
- `serial_in`  out  1  sampled data bit, LSB first; stable from one `shift` until the next.
- `rx_done`  out  1  one-cycle pulse; frame complete with a valid stop bit.
- `frame_err`  out  1  one-cycle pulse; stop bit sampled low.
- `busy`  out  1  high in any state other than IDLE.

## Operation
- `rx` passes through a 2-flop synchroniser whose reset value is 1. The output is `rx_s`; all decisions use `rx_s` only.
- State machine states: IDLE, START, DATA, STOP, WAIT_HIGH.
- Counters:
  - `cnt`: ⌈log2 OVERSAMPLE⌉ bits.
  - `bit_idx`: ⌈log2 DATA_WIDTH⌉ bits.
- IDLE: when `rx_s`==0, go to START with `cnt`=0.
- START: `cnt` increments each cycle. At `cnt`==OVERSAMPLE/2−1, check `rx_s`:
  - `rx_s`==0: go to DATA with `cnt`=0 and `bit_idx`=0.
  - `rx_s`==1: false start. Return to IDLE; no outputs pulse.
- DATA: at `cnt`==OVERSAMPLE−1:
  - Register `serial_in`←`rx_s` and `shift`←1 for one cycle.
  - Set `cnt`←0.
  - If `bit_idx`==DATA_WIDTH−1, go to STOP; otherwise increment `bit_idx`.
- STOP: at `cnt`==OVERSAMPLE−1, sample `rx_s`:
  - 1: pulse `rx_done`, go to IDLE.
  - 0: pulse `frame_err`, go to WAIT_HIGH.
- WAIT_HIGH: stay until `rx_s`==1, then go to IDLE. This stops a stuck-low line or break condition from retriggering.
- Exactly DATA_WIDTH `shift` pulses are issued per accepted frame; none are issued for a false start.
- `rx_done` and `frame_err` are mutually exclusive and never coincide with `shift`.
- Returning to IDLE at mid-stop-bit allows back-to-back frames with no idle gap.
- Reset values:
  - State IDLE; `cnt`=0; `bit_idx`=0.
  - `shift`=0, `serial_in`=1, `rx_done`=0, `frame_err`=0, `busy`=0.
  - Synchroniser flops = 1.
- Reset asserted mid-frame:
  - Takes effect on the next `rx_clk` edge: all outputs go to reset values and the partial frame is discarded.
  - After reset releases, the line must be seen low from IDLE before a new frame starts.

## Timing
- All outputs are registered.
- Let cycle D be the edge on which IDLE sees `rx_s`==0. Synchroniser latency from the `rx` pin is 2 cycles before D.
- Start check occurs at edge D+OVERSAMPLE/2.
- `shift` for bit k (k = 0..DATA_WIDTH−1) is high during cycle D+OVERSAMPLE/2+(k+1)·OVERSAMPLE+1.
- `rx_done`/`frame_err` is high during cycle D+OVERSAMPLE/2+(DATA_WIDTH+1)·OVERSAMPLE+1.
- Example, OVERSAMPLE=16 and DATA_WIDTH=8:
  - First `shift` at D+25.
  - `rx_done` at D+153.
- Earliest next start detection is the cycle after `rx_done`.

## Structure
- `uart_params.vh` holds:
  - `DATA_WIDTH`.
  - `OVERSAMPLE`.
  - State encodings: `RX_IDLE`, `RX_START`, `RX_DATA`, `RX_STOP`, `RX_WAIT_HIGH`.
- One sub-module, `sync_2ff`: 2-flop synchroniser with synchronous reset to a parameterised value (here 1). The transmitter and any other async input reuse it.
- The FSM, counters and output registers stay in `uart_rx_ctrl`.

## Test plan
All scenarios use OVERSAMPLE=16 and DATA_WIDTH=8; each bit is held 16 cycles.
- Frame 0xA5 with stop=1:
  - 8 `shift` pulses spaced 16 cycles apart, the first at D+25.
  - `serial_in` sequence at the pulses: 1,0,1,0,0,1,0,1.
  - Single `rx_done` at D+153; `frame_err` never asserted.
- Glitch: `rx` low for 4 cycles, then high:
  - `busy` is high for ≤9 cycles.
  - No `shift`, `rx_done` or `frame_err`; FSM returns to IDLE.
- Frame 0x3C with stop bit low, line held low 40 more cycles, then high, then frame 0x81:
  - `frame_err` pulses once.
  - No activity while the line stays low.
  - 0x81 frame yields bits 1,0,0,0,0,0,0,1 and `rx_done`.
- Back-to-back 0x00 then 0xFF with no idle gap:
  - 16 `shift` pulses total.
  - Two `rx_done` pulses, 160 cycles apart.
- `rst` asserted for 1 cycle after the 4th `shift` of a frame, line then left idle:
  - All outputs at reset values the next cycle.
  - No further `shift` or `rx_done`.
  - A following 0x5A frame is received correctly.
